vga_counter_bank: RTL

// - Parametrised bank of NUM_CH counters, CNT_W bits each, driven by debounced push buttons.
// - Feeds the packed data_raw bus of the VGA text generator; supersedes the fixed 16x16 all-increment logic.
// - Adds decrement, a per-channel or all-channel mode, a channel selector and optional saturation.
// - Adds frame-synchronous (tear-free) output update.

---
 rtl/vga_counter_bank.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_counter_bank.sv
// -----------------------------------------------------------------------------
// vga_counter_bank
//
// A bank of NUM_CH counters, each CNT_W bits wide. Three push buttons control
// the bank. inc adds one and dec subtracts one. next selects the channel that
// inc/dec act on when mode_all is low. When mode_all is high, inc/dec act on
// every channel.
//
// The counters are copied to the packed data_raw bus only on frame_tick. The
// VGA text generator therefore never sees a value change part-way through a
// frame.
//
// Each button passes through these stages, in order:
//   1. A 2-flop synchroniser, clocked on every clk.
//   2. Two sample flops, s1 and s2, that load only on the debounce tick. The
//      debounced level is s1 & s2.
//   3. A one-clk press pulse on each rising edge of the debounced level.
//
// The counters and sel update on the clk after the press pulse.
//
// Optional feature (compile-time macro AUTO_REPEAT_EN):
//   inc and dec auto-repeat while held. The first repeat comes REPEAT_DLY
//   sample ticks after the first pulse. Later repeats follow every
//   REPEAT_RATE ticks. next never repeats. Without the macro, no repeat logic
//   is built and REPEAT_* only feed the parameter range checks.
//
// Ports:
//   clk         in   1               system clock
//   reset       in   1               synchronous, active-high reset
//   btn_inc     in   1               raw increment button (async, bouncy)
//   btn_dec     in   1               raw decrement button (async, bouncy)
//   btn_next    in   1               raw select-next-channel button
//   mode_all    in   1               1: inc/dec act on all channels; 0: on sel
//   frame_tick  in   1               one-clk pulse at frame start
//   sel         out  $clog2(NUM_CH)  currently selected channel
//   data_raw    out  NUM_CH*CNT_W    frame-latched counters,
//                                    channel i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module vga_counter_bank #(
  parameter int NUM_CH       = 16,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_DIV = 250000,
  parameter int SATURATE     = 0,
  parameter int INIT_INDEX   = 1,
  parameter int REPEAT_DLY   = 200,
  parameter int REPEAT_RATE  = 40
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        btn_inc,
  input  logic                        btn_dec,
  input  logic                        btn_next,
  input  logic                        mode_all,
  input  logic                        frame_tick,
  output logic [$clog2(NUM_CH)-1:0]   sel,
  output logic [NUM_CH*CNT_W-1:0]     data_raw
);

  localparam int SEL_W = $clog2(NUM_CH);
  localparam int DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  // Bit positions inside the per-button vectors.
  localparam int B_INC  = 0;
  localparam int B_DEC  = 1;
  localparam int B_NEXT = 2;

  // Parameter range checks, evaluated at elaboration.
  if (NUM_CH < 2) begin : g_chk_num_ch
    $error("vga_counter_bank: NUM_CH must be at least 2");
  end
  if (CNT_W < 1) begin : g_chk_cnt_w
    $error("vga_counter_bank: CNT_W must be at least 1");
  end
  if (DEBOUNCE_DIV < 1) begin : g_chk_div
    $error("vga_counter_bank: DEBOUNCE_DIV must be at least 1");
  end
  if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_chk_repeat
    $error("vga_counter_bank: REPEAT_DLY and REPEAT_RATE must be at least 1");
  end

  // Reset value of channel idx: its own index, or zero.
  function automatic logic [CNT_W-1:0] init_val(input int idx);
    logic [CNT_W-1:0] r;
    r = '0;
    if (INIT_INDEX != 0) begin
      r = CNT_W'(idx);
    end
    return r;
  endfunction

  // One counter step: wraps modulo 2^CNT_W, or clamps at 0 and all-ones.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] v,
                                                input logic             up);
    logic [CNT_W-1:0] r;
    r = v;
    if (up) begin
      if (!(SATURATE != 0 && v == {CNT_W{1'b1}})) begin
        r = v + 1'b1;
      end
    end else begin
      if (!(SATURATE != 0 && v == '0)) begin
        r = v - 1'b1;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Debounce sample-tick divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  logic [2:0] btn_raw;
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic [2:0] smp_s1;
  logic [2:0] smp_s2;
  logic [2:0] level;
  logic [2:0] lvl_p2;
  logic [2:0] rep_pulse;
  logic [2:0] press_p3;

  assign btn_raw = {btn_next, btn_dec, btn_inc};
  assign level   = smp_s1 & smp_s2;

  // ---------------------------------------------------------------------------
  // Stage p0/p1: synchroniser; tick-gated sample pair; level edge -> press p3
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      smp_s1   <= '0;
      smp_s2   <= '0;
      lvl_p2   <= '0;
      press_p3 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      if (tick) begin
        smp_s1 <= sync_p1;
        smp_s2 <= smp_s1;
      end
      lvl_p2   <= level;
      press_p3 <= (level & ~lvl_p2) | rep_pulse;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  // rep_cnt counts sample ticks seen with the level high since the last
  // pulse. rep_first selects the initial delay or the repeat period.
  logic [REP_W-1:0] rep_cnt [2];
  logic [1:0]       rep_first;
  logic [1:0]       rep_hit;

  always_comb begin
    rep_hit = '0;
    for (int b = 0; b < 2; b++) begin
      if (tick && level[b] &&
          (rep_cnt[b] + REP_W'(1)) ==
            (rep_first[b] ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE))) begin
        rep_hit[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        rep_cnt[b] <= '0;
      end
      rep_first <= 2'b11;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (!level[b]) begin
          rep_cnt[b]   <= '0;
          rep_first[b] <= 1'b1;
        end else if (tick) begin
          if (rep_hit[b]) begin
            rep_cnt[b]   <= '0;
            rep_first[b] <= 1'b0;
          end else begin
            rep_cnt[b] <= rep_cnt[b] + 1'b1;
          end
        end
      end
    end
  end

  assign rep_pulse = {1'b0, rep_hit};
`else
  assign rep_pulse = '0;
`endif

  // Opposing inc and dec pulses in the same clk cancel out.
  logic do_inc;
  logic do_dec;

  assign do_inc = press_p3[B_INC] & ~press_p3[B_DEC];
  assign do_dec = press_p3[B_DEC] & ~press_p3[B_INC];

  // ---------------------------------------------------------------------------
  // Stage p4: live counters and channel selector
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] live [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        live[i] <= init_val(i);
      end
    end else if (do_inc || do_dec) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (mode_all || sel == SEL_W'(i)) begin
          live[i] <= cnt_step(live[i], do_inc);
        end
      end
    end
  end

  // The counter block above sees the old sel in the same clk, so a press of
  // next together with inc/dec acts on the previous channel first.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= '0;
    end else if (press_p3[B_NEXT]) begin
      if (sel == SEL_W'(NUM_CH - 1)) begin
        sel <= '0;
      end else begin
        sel <= sel + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p5: frame-synchronous output latch
  // ---------------------------------------------------------------------------
  // When frame_tick and a counter update fall in the same clk, data_raw takes
  // the pre-update values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_raw[i*CNT_W +: CNT_W] <= init_val(i);
      end
    end else if (frame_tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_raw[i*CNT_W +: CNT_W] <= live[i];
      end
    end
  end

endmodule
